// File: rtl/data_stack.sv
// data_stack -- hardware data stack for a small stack-machine CPU.
//
// Holds up to DEPTH entries of DW bits. top/next feed the ALU operand
// inputs directly and are derived combinationally from the registered
// depth and storage, so an operation applied at one edge is visible
// immediately after it. One operation executes per enabled cycle; illegal
// operations (overflow/underflow) leave all state untouched.
//
// Optional feature: define DATA_STACK_ERR_EN to compile in the sticky
// overflow (ovf) and underflow (unf) flags. Without it both are tied to 0.

module data_stack #(
    parameter int DEPTH = 16,   // power of two, 4..256
    parameter int DW    = 16
) (
    input  logic                       clk,
    input  logic                       reset,    // synchronous, active-low
    input  logic                       en,       // 0 freezes all state
    input  logic [2:0]                 stackOP,
    input  logic [DW-1:0]              din,
    output logic [DW-1:0]              top,
    output logic [DW-1:0]              next,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf,
    output logic                       unf
);

    localparam int AW = $clog2(DEPTH);     // storage index width
    localparam int CW = AW + 1;            // entry count width (0..DEPTH)
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Operation encoding; 6 and 7 fall into the default arm and act as NONE.
    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POPREP  = 3'd2,
        OP_POP     = 3'd3,
        OP_POP2    = 3'd4,
        OP_SWAP    = 3'd5
    } stack_op_e;

    // Registered state.
    logic [DW-1:0] r_mem [DEPTH];
    logic [CW-1:0] r_depth;

    // Derived occupancy and index values.
    logic          w_ge1;
    logic          w_ge2;
    logic          w_full;
    logic [AW-1:0] w_push_idx;
    logic [AW-1:0] w_top_idx;
    logic [AW-1:0] w_next_idx;

    // Decoded operation.
    logic          w_legal;
    logic [CW-1:0] w_depth_nxt;
    logic          w_wr0_en;
    logic [AW-1:0] w_wr0_addr;
    logic [DW-1:0] w_wr0_data;
    logic          w_wr1_en;
    logic [AW-1:0] w_wr1_addr;
    logic [DW-1:0] w_wr1_data;
    logic          w_commit;

    // Occupancy flags and storage indices; low AW bits wrap correctly
    // because indices are only used when the matching entry exists.
    assign w_ge1      = (r_depth != '0);
    assign w_ge2      = (r_depth >= CW'(2));
    assign w_full     = (r_depth == FULL_CNT);
    assign w_push_idx = r_depth[AW-1:0];
    assign w_top_idx  = r_depth[AW-1:0] - AW'(1);
    assign w_next_idx = r_depth[AW-1:0] - AW'(2);

    // An operation takes effect only out of reset, when enabled and legal.
    assign w_commit   = reset && en && w_legal;

    // Decode the requested operation into legality, next depth and writes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        w_legal     = 1'b0;
        w_depth_nxt = r_depth;
        w_wr0_en    = 1'b0;
        w_wr0_addr  = '0;
        w_wr0_data  = '0;
        w_wr1_en    = 1'b0;
        w_wr1_addr  = '0;
        w_wr1_data  = '0;

        case (stackOP)
            OP_PUSH: begin
                w_legal     = !w_full;
                w_depth_nxt = r_depth + CW'(1);
                w_wr0_en    = 1'b1;
                w_wr0_addr  = w_push_idx;
                w_wr0_data  = din;
            end
            OP_POPREP: begin
                // Drop top, overwrite the old second entry: din becomes top.
                w_legal     = w_ge2;
                w_depth_nxt = r_depth - CW'(1);
                w_wr0_en    = 1'b1;
                w_wr0_addr  = w_next_idx;
                w_wr0_data  = din;
            end
            OP_POP: begin
                w_legal     = w_ge1;
                w_depth_nxt = r_depth - CW'(1);
            end
            OP_POP2: begin
                w_legal     = w_ge2;
                w_depth_nxt = r_depth - CW'(2);
            end
            OP_SWAP: begin
                // Two write ports so the exchange completes in one cycle.
                w_legal     = w_ge2;
                w_wr0_en    = 1'b1;
                w_wr0_addr  = w_top_idx;
                w_wr0_data  = r_mem[w_next_idx];
                w_wr1_en    = 1'b1;
                w_wr1_addr  = w_next_idx;
                w_wr1_data  = r_mem[w_top_idx];
            end
            default: begin
                // OP_NONE and the unused codes 6/7 leave everything alone.
                w_legal     = 1'b0;
            end
        endcase
    end

    // Entry count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            r_depth <= '0;
        end else if (w_commit) begin
            r_depth <= w_depth_nxt;
        end
    end

    // Storage array writes (up to two entries per cycle for SWAP).
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; entries at or above depth
        // are never visible, so clearing them would only cost reset fan-out.
        if (w_commit) begin
            if (w_wr0_en) begin
                r_mem[w_wr0_addr] <= w_wr0_data;
            end
            if (w_wr1_en) begin
                r_mem[w_wr1_addr] <= w_wr1_data;
            end
        end
    end

`ifdef DATA_STACK_ERR_EN
    logic r_ovf;
    logic r_unf;
    logic w_ovf_set;
    logic w_unf_set;

    // An enabled op that was refused raises the flag for its direction.
    assign w_ovf_set = en && !w_legal && (stackOP == OP_PUSH);
    assign w_unf_set = en && !w_legal &&
                       ((stackOP == OP_POPREP) || (stackOP == OP_POP) ||
                        (stackOP == OP_POP2)   || (stackOP == OP_SWAP));

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign ovf = r_ovf;
    assign unf = r_unf;
`else
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

    // Combinational outputs from registered state; absent entries read 0.
    assign top   = w_ge1 ? r_mem[w_top_idx]  : '0;
    assign next  = w_ge2 ? r_mem[w_next_idx] : '0;
    assign depth = r_depth;
    assign empty = !w_ge1;
    assign full  = w_full;

endmodule

// File: doc/data_stack.md
DATA_STACK -- requirements
Module: data_stack

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, meaning the number of 16-bit entries; legal values are powers of two from 4 to 256.
REQ-002 SHALL provide parameter DW, default 16, meaning the data width.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL provide port en, input, 1 bit: operation enable, driven from PCWrite; 0 freezes all state (halt).
REQ-006 SHALL provide port stackOP, input, 3 bits: 0 NONE, 1 PUSH, 2 POPANDREPLACE, 3 POP, 4 POP2, 5 SWAP; values 6 and 7 act as NONE.
REQ-007 SHALL provide port din, input, DW bits: the write value, already selected upstream per stackControl (IMM/IMMLUI/MEM/ALU/INPUT).
REQ-008 SHALL provide port top, output, DW bits: the top-of-stack entry (ALU operand A).
REQ-009 SHALL provide port next, output, DW bits: the second entry (ALU operand B).
REQ-010 SHALL provide port depth, output, log2(DEPTH)+1 bits: the current entry count.
REQ-011 SHALL provide ports empty and full, outputs, 1 bit each: asserted when depth==0 and depth==DEPTH respectively.
REQ-012 SHALL provide ports ovf and unf, outputs, 1 bit each: sticky overflow and underflow flags.

Function
REQ-013 SHALL hold entries in a DEPTH x DW storage array indexed by depth; top=entry[depth-1] and next=entry[depth-2].
REQ-014 SHALL drive top=0 when depth<1 and next=0 when depth<2.
REQ-015 SHALL derive top, next, depth, empty and full combinationally from registered state, so an operation sampled at edge N is visible right after edge N (one-cycle latency) and upstream ALU results computed from top/next are valid in the same cycle.
REQ-016 SHALL implement PUSH as: entry[depth]=din, depth+1; legal only when depth<DEPTH.
REQ-017 SHALL implement POPANDREPLACE as: entry[depth-2]=din, depth-1; legal only when depth>=2.
REQ-018 SHALL implement POP as depth-1 (legal when depth>=1) and POP2 as depth-2 (legal when depth>=2); storage contents are left unchanged.
REQ-019 SHALL implement SWAP by exchanging entry[depth-1] and entry[depth-2] in one cycle, depth unchanged; legal only when depth>=2.
REQ-020 SHALL NOT change any state for an illegal operation (push when full, or insufficient entries for the op) or when en=0.
REQ-021 SHALL make depth saturate in the sense that it never wraps below 0 or above DEPTH.
REQ-022 SHALL execute exactly one operation per cycle; PUSH at depth==DEPTH-1 SHALL be legal and set full on the next cycle.

Reset
REQ-023 SHALL, when reset==0 at a rising edge, set depth=0, ovf=0 and unf=0, regardless of en and stackOP.
REQ-024 SHALL leave storage contents uncleared by reset; outputs after reset are top=0, next=0, empty=1, full=0.
REQ-025 SHALL, on reset asserted mid-sequence, abandon any pending op, and the first op after deassertion SHALL act on an empty stack.

Configuration
REQ-026 SHALL use the macro DATA_STACK_ERR_EN to compile the error flags in or out.
REQ-027 SHALL, with DATA_STACK_ERR_EN defined, set ovf on an illegal PUSH with en=1 and set unf on an illegal POP, POP2, POPANDREPLACE or SWAP with en=1; both flags stay set until reset.
REQ-028 SHALL, without DATA_STACK_ERR_EN, tie ovf and unf to 0 while still suppressing illegal ops per REQ-020.

Verification
REQ-029 SHALL cover reset then PUSH 0x0005, PUSH 0x0003 -> depth=2, top=0x0003, next=0x0005, empty=0.
REQ-030 SHALL cover, from REQ-029's state, POPANDREPLACE with din=0x0008 -> depth=1, top=0x0008, next=0.
REQ-031 SHALL cover PUSH 0x000A, 0x000B, then SWAP -> top=0x000A, next=0x000B, depth unchanged.
REQ-032 SHALL cover DEPTH=16 with 16 PUSHes -> full=1; a 17th PUSH 0xFFFF -> depth=16, top unchanged, ovf=1 (macro defined) or ovf=0 (macro undefined).
REQ-033 SHALL cover, on an empty stack, POP2 -> depth=0, unf=1 (macro defined); then en=0 with PUSH 0x1234 -> no change.
REQ-034 SHALL cover reset asserted during a PUSH stream at depth=3 -> depth=0, ovf=unf=0 next cycle, top=0.
